// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment readback block.
package seg7_pkg;

    localparam int SEG_W = 7;
    localparam int SUM_W = 8;
    localparam int ERR_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        CAPTURE = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Active-low patterns, bit0 = A ... bit6 = G
    localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
    localparam logic [SEG_W-1:0] SEG_A = 7'h08;
    localparam logic [SEG_W-1:0] SEG_B = 7'h03;
    localparam logic [SEG_W-1:0] SEG_C = 7'h46;
    localparam logic [SEG_W-1:0] SEG_D = 7'h21;
    localparam logic [SEG_W-1:0] SEG_E = 7'h06;
    localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment pattern to hex digit decoder.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       digit,
    output logic             ok
);

    always_comb begin
        digit = 4'h0;
        ok    = 1'b1;
        unique case (seg)
            SEG_0:   digit = 4'h0;
            SEG_1:   digit = 4'h1;
            SEG_2:   digit = 4'h2;
            SEG_3:   digit = 4'h3;
            SEG_4:   digit = 4'h4;
            SEG_5:   digit = 4'h5;
            SEG_6:   digit = 4'h6;
            SEG_7:   digit = 4'h7;
            SEG_8:   digit = 4'h8;
            SEG_9:   digit = 4'h9;
            SEG_A:   digit = 4'hA;
            SEG_B:   digit = 4'hB;
            SEG_C:   digit = 4'hC;
            SEG_D:   digit = 4'hD;
            SEG_E:   digit = 4'hE;
            SEG_F:   digit = 4'hF;
            default: ok    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Debounced capture of a 7-segment pattern into digit, running sum and error flags.
// Define ERR_COUNT_EN to build the saturating ERR_CNT counter.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             CLOCK_50,
    input  logic             RST_N,
    input  logic [SEG_W-1:0] SW,
    input  logic             KEY1,
    output logic [3:0]       VALUE,
    output logic             VALID,
    output logic             ERROR,
    output logic [SUM_W-1:0] SUM,
    output logic [ERR_W-1:0] ERR_CNT
);

    localparam int         CNT_W = 20;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       key_q;
    logic [SEG_W-1:0] sw_q;
    logic [SEG_W-1:0] sw_s;
    logic             key_s;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    logic [3:0]       dig;
    logic             dig_ok;

    assign key_s = key_q[1];

    // Synchronisers idle at "released key, blank display"
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            key_q <= 2'b11;
            sw_q  <= '1;
            sw_s  <= '1;
        end else begin
            key_q <= {key_q[0], KEY1};
            sw_q  <= SW;
            sw_s  <= sw_q;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!key_s) state_n = PRESS;
            end
            PRESS: begin
                if (key_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = CAPTURE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            CAPTURE: begin
                state_n = RELEASE;
                cnt_n   = '0;
            end
            RELEASE: begin
                if (!key_s) begin
                    cnt_n = '0;
                end else if (cnt == LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    seg7_to_hex u_dec (
        .seg   (sw_s),
        .digit (dig),
        .ok    (dig_ok)
    );

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            VALUE <= '0;
            VALID <= 1'b0;
            ERROR <= 1'b0;
            SUM   <= '0;
        end else begin
            VALID <= 1'b0;
            if (state == CAPTURE) begin
                if (dig_ok) begin
                    VALUE <= dig;
                    SUM   <= SUM + {{(SUM_W-4){1'b0}}, dig};
                    ERROR <= 1'b0;
                    VALID <= 1'b1;
                end else begin
                    ERROR <= 1'b1;
                end
            end
        end
    end

`ifdef ERR_COUNT_EN
    logic [ERR_W-1:0] err_cnt;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            err_cnt <= '0;
        end else if (state == CAPTURE && !dig_ok && err_cnt != '1) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

    assign ERR_CNT = err_cnt;
`else
    assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader with DEBOUNCE_CYCLES = 4.
module tb_seg7_reader;

    localparam int DEB = 4;

    logic       CLOCK_50;
    logic       RST_N;
    logic [6:0] SW;
    logic       KEY1;
    logic [3:0] VALUE;
    logic       VALID;
    logic       ERROR;
    logic [7:0] SUM;
    logic [3:0] ERR_CNT;

    typedef struct {
        int v;
        int s;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errs    = 0;
    int   cyc     = 0;
    int   vcyc    = 0;
    int   e_val   = 0;
    int   e_sum   = 0;
    int   e_err   = 0;
    int   e_cnt   = 0;

    seg7_reader #(.DEBOUNCE_CYCLES(DEB)) dut (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .SW       (SW),
        .KEY1     (KEY1),
        .VALUE    (VALUE),
        .VALID    (VALID),
        .ERROR    (ERROR),
        .SUM      (SUM),
        .ERR_CNT  (ERR_CNT)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_dec(input logic [6:0] p);
        case (p)
            7'h40: return 0;
            7'h79: return 1;
            7'h24: return 2;
            7'h30: return 3;
            7'h19: return 4;
            7'h12: return 5;
            7'h02: return 6;
            7'h78: return 7;
            7'h00: return 8;
            7'h10: return 9;
            7'h08: return 10;
            7'h03: return 11;
            7'h46: return 12;
            7'h21: return 13;
            7'h06: return 14;
            7'h0E: return 15;
            default: return -1;
        endcase
    endfunction

    always @(negedge CLOCK_50) begin
        if (RST_N && VALID) begin
            vcyc = cyc;
            if (q.size() == 0) begin
                chk("valid_unexpected", VALID, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("value", VALUE, e.v);
                chk("sum", SUM, e.s);
                chk("error_on_valid", ERROR, 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check_state(input string tag);
        @(negedge CLOCK_50);
        chk({tag, "_pending"}, q.size(), 0);
        chk({tag, "_value"}, VALUE, e_val);
        chk({tag, "_sum"}, SUM, e_sum);
        chk({tag, "_error"}, ERROR, e_err);
`ifdef ERR_COUNT_EN
        chk({tag, "_errcnt"}, ERR_CNT, e_cnt);
`else
        chk({tag, "_errcnt"}, ERR_CNT, 0);
`endif
        tick(1);
    endtask

    task automatic model_capture(input logic [6:0] p);
        int d;
        exp_t e;
        d = ref_dec(p);
        if (d >= 0) begin
            e_val = d;
            e_sum = (e_sum + d) % 256;
            e_err = 0;
            e.v = e_val;
            e.s = e_sum;
            q.push_back(e);
        end else begin
            e_err = 1;
            if (e_cnt < 15) e_cnt++;
        end
    endtask

    task automatic press(input logic [6:0] p, input int hold, input string tag);
        SW = p;
        tick(3);
        model_capture(p);
        KEY1 = 1'b0;
        tick(hold);
        KEY1 = 1'b1;
        tick(DEB + 6);
        check_state(tag);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        KEY1  = 1'b1;
        SW    = 7'h7F;
        q.delete();
        e_val = 0;
        e_sum = 0;
        e_err = 0;
        e_cnt = 0;
        tick(3);
        RST_N = 1'b1;
        tick(1);
    endtask

    initial begin
        int rel;
        do_reset();

        tick(20);
        check_state("idle");

        press(7'h30, 20, "clean3");

        SW = 7'h24;
        repeat (4) begin
            KEY1 = 1'b0;
            tick(2);
            KEY1 = 1'b1;
            tick(2);
        end
        @(negedge CLOCK_50);
        chk("bounce_no_capture_sum", SUM, e_sum);
        tick(1);
        press(7'h24, 12, "bounce2");

        press(7'h7E, 10, "invalid");
        press(7'h79, 10, "after_inv");

        do_reset();
        repeat (17) press(7'h0E, 10, "f_acc");
        @(negedge CLOCK_50);
        chk("sum_255", SUM, 255);
        tick(1);
        press(7'h79, 10, "wrap");
        @(negedge CLOCK_50);
        chk("sum_wrap", SUM, 0);
        tick(1);

        do_reset();
        SW = 7'h30;
        tick(3);
        KEY1 = 1'b0;
        tick(4);
        RST_N = 1'b0;
        tick(2);
        @(negedge CLOCK_50);
        chk("rst_value", VALUE, 0);
        chk("rst_sum", SUM, 0);
        chk("rst_valid", VALID, 0);
        tick(0);
        @(posedge CLOCK_50);
        #1;
        RST_N = 1'b1;
        rel = cyc;
        model_capture(7'h30);
        tick(12);
        KEY1 = 1'b1;
        tick(DEB + 6);
        chk("rst_latency", vcyc - rel, DEB + 4);
        check_state("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Reads back an active-low 7-segment pattern, such as the adder result patterns shown on HEX7, and recovers the hex digit it represents. The pattern is presented on switches and captured on a debounced key press. Each valid capture is added into a running 8-bit sum, and invalid patterns are flagged. It sits on the board-level top alongside the adder/display blocks as their readback/checking counterpart.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 500000: consecutive stable cycles required on KEY1 (10 ms at 50 MHz); legal range 2..2^20-1.

Ports:
- CLOCK_50  input  1  single system clock; all state on rising edge.
- RST_N  input  1  reset; asynchronous assert, active-low.
- SW  input  7  segment pattern; bit0=A, bit1=B, …, bit6=G; 0 = segment lit.
- KEY1  input  1  raw capture button; active-low, bouncy, asynchronous.
- VALUE  output  4  digit from the last valid capture.
- VALID  output  1  one-cycle pulse per capture with a recognised pattern.
- ERROR  output  1  set on an unrecognised capture; cleared on the next valid capture.
- SUM  output  8  running sum of valid VALUEs, modulo 256.
- ERR_CNT  output  4  count of invalid captures, saturating at 15.

## Operation
- KEY1 and SW each pass through a 2-flop synchroniser; all logic below uses the synchronised copies (key_s, sw_s).
- Decode map, sw_s to VALUE, with 0x7F shown as 7'h7F:
  - 40→0, 79→1, 24→2, 30→3
  - 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→b
  - 46→C, 21→d, 06→E, 0E→F
  - Every other pattern is invalid.
- FSM states: IDLE, PRESS, CAPTURE, RELEASE.
  - IDLE: counter = 0. When key_s = 0, go to PRESS.
  - PRESS: counter increments each cycle while key_s = 0. If key_s = 1, go to IDLE and clear the counter. When counter = DEBOUNCE_CYCLES-1 and key_s = 0, go to CAPTURE.
  - CAPTURE: lasts one cycle. Decodes sw_s and updates the outputs at the end of the cycle. Then goes to RELEASE with counter cleared.
  - RELEASE: counter increments while key_s = 1 and clears whenever key_s = 0. When counter = DEBOUNCE_CYCLES-1 and key_s = 1, go to IDLE.
- Capture update, valid pattern: VALUE ← digit; SUM ← SUM + digit (8-bit, wraps 255→0 silently); ERROR ← 0; VALID pulses for one cycle.
- Capture update, invalid pattern: VALUE and SUM hold; ERROR ← 1; ERR_CNT increments, holding at 15; VALID stays 0.
- Holding KEY1 low produces exactly one capture. A new capture needs a debounced release first.
- Reset mid-operation (any state): return to IDLE immediately and clear all outputs and counters. A key still held after reset must pass PRESS again before it is captured.

## Timing
- Reset values: VALUE = 0, VALID = 0, ERROR = 0, SUM = 0, ERR_CNT = 0, state = IDLE, counter = 0, synchronisers = 1 (released key; SW pattern 7'h7F).
- All outputs are registered. No combinational path from any input to any output.
- Latency: let edge E be the first edge at which key_s = 0. VALID is high in the cycle after edge E + DEBOUNCE_CYCLES + 1. Add 2 cycles of synchroniser delay relative to the raw KEY1 fall.
- SW must be stable from 2 cycles before CAPTURE through CAPTURE. A change during PRESS is harmless; the value present at CAPTURE is used.
- Debounce boundary: a bounce at counter = DEBOUNCE_CYCLES-2 restarts the count. A count reaching DEBOUNCE_CYCLES-1 with key_s still low captures.

## Configuration
- ERR_COUNT_EN defined: the ERR_CNT saturating counter is present.
- ERR_COUNT_EN undefined: ERR_CNT is tied to 4'h0 and no counter flops are built. ERROR behaves identically in both builds.

## Structure
- Package seg7_pkg holds:
  - the state enum (IDLE/PRESS/CAPTURE/RELEASE);
  - the 16 segment pattern constants (SEG_0 … SEG_F);
  - the width constants (SEG_W = 7, SUM_W = 8, ERR_W = 4).
- Sub-module seg7_to_hex: purely combinational; 7-bit pattern in, 4-bit digit plus a valid flag out. It is reusable by other readback blocks.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset, then idle for 20 cycles → all outputs 0, VALID never high.
- SW = 7'h30, clean KEY1 press held for 10 cycles → one VALID pulse, VALUE = 3, SUM = 3; no second pulse while KEY1 stays held.
- SW = 7'h24, KEY1 bounces low/high every 2 cycles, then held low → no capture during bouncing; one capture after the stable hold, VALUE = 2.
- SW = 7'h7E (invalid), press and release → ERROR = 1, ERR_CNT = 1 (0 without ERR_COUNT_EN), VALUE and SUM unchanged. Then SW = 7'h79 press → VALUE = 1, ERROR = 0.
- Seventeen valid captures of SW = 7'h0E (F) → SUM = 255 after the 17th; an 18th capture of 7'h79 → SUM = 0 (wrap).
- Assert RST_N low while in PRESS with KEY1 held low, then release reset → outputs 0; a capture occurs only after a full debounce following reset.
